// File: rtl/tick_pkg.sv
// tick_pkg: shared defaults and types for the tick scheduler.
//   CLOCK_FREQUENCY_DEF / NUM_CH_DEF / PERIOD_W_DEF : default parameter values
//   ch_idx_t : channel index at the default channel count
//   ch_cfg_t : channel configuration {period, enable} at the default period width
//   idx_w()  : counter width for a modulus, never below one bit
package tick_pkg;
    localparam int CLOCK_FREQUENCY_DEF = 500;
    localparam int NUM_CH_DEF = 4;
    localparam int PERIOD_W_DEF = 8;
    typedef logic [$clog2(NUM_CH_DEF)-1:0] ch_idx_t;
    typedef struct packed {
        logic [PERIOD_W_DEF-1:0] period;
        logic                    enable;
    } ch_cfg_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over a pending vector.
//   pending : request bits, one per channel
//   ptr     : highest-priority channel for this pick
//   grant   : first pending channel at or after ptr (wrapping); 0 when none
//   any     : at least one request pending
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         pending,
    input  logic [$clog2(NUM_CH)-1:0] ptr,
    output logic [$clog2(NUM_CH)-1:0] grant,
    output logic                      any
);
    localparam int IW = $clog2(NUM_CH);
    // Scan from the farthest offset down so the closest pending channel to ptr is written last.
    always_comb begin
        grant = '0;
        any = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[(int'(ptr) + i) % NUM_CH]) begin
                grant = IW'((int'(ptr) + i) % NUM_CH);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler feeding per-channel periodic counters, events delivered round-robin.
//   ClockIn/ResetN : clock, asynchronous active-low reset
//   Run            : advance prescaler and channel counters
//   CfgWrite/CfgChannel/CfgPeriod/CfgEnable : per-channel configuration strobe
//   EventReady     : consumer accepts the presented event
//   ClearOverrun   : per-channel clear of sticky overrun bits
//   BaseTick       : one-cycle pulse per base tick
//   EventValid/EventChannel : registered event port
//   Overrun        : sticky, channel fired while its previous event was still pending
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = CLOCK_FREQUENCY_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                      ClockIn,
    input  logic                      ResetN,
    input  logic                      Run,
    input  logic                      CfgWrite,
    input  logic [$clog2(NUM_CH)-1:0] CfgChannel,
    input  logic [PERIOD_W-1:0]       CfgPeriod,
    input  logic                      CfgEnable,
    input  logic                      EventReady,
    input  logic [NUM_CH-1:0]         ClearOverrun,
    output logic                      BaseTick,
    output logic                      EventValid,
    output logic [$clog2(NUM_CH)-1:0] EventChannel,
    output logic [NUM_CH-1:0]         Overrun
);
    localparam int IW = $clog2(NUM_CH);
    localparam int PW = idx_w(CLOCK_FREQUENCY);
    localparam logic [PW-1:0] PS_LOAD = PW'(CLOCK_FREQUENCY - 1);
    typedef logic [IW-1:0] idx_t;
    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic                enable;
    } cfg_t;

    logic [PW-1:0]     presc_q, presc_d;
    logic              base_tick;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [NUM_CH-1:0] acc_mask, arb_pend;
    idx_t              ptr_q, ptr_d, chan_q, chan_d, arb_grant;
    logic              valid_q, valid_d, accept, hold, arb_any;

    assign base_tick = Run && presc_q == '0;

    always_comb begin
        presc_d = base_tick ? PS_LOAD : Run ? presc_q - PW'(1) : presc_q;
    end

    // Channel counters: a write reloads the counter and suppresses a coincident fire.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cfg_t                cfg_q, cfg_d;
        logic [PERIOD_W-1:0] cnt_q, cnt_d, p_new;
        logic                wr, fire_c;
        always_comb begin
            wr = CfgWrite && CfgChannel == idx_t'(c);
            p_new = CfgPeriod == '0 ? PERIOD_W'(1) : CfgPeriod;
            fire_c = !wr && base_tick && cfg_q.enable && cnt_q == '0;
            cfg_d = wr ? {p_new, CfgEnable} : cfg_q;
            cnt_d = wr ? p_new - PERIOD_W'(1)
                  : fire_c ? cfg_q.period - PERIOD_W'(1)
                  : (base_tick && cfg_q.enable) ? cnt_q - PERIOD_W'(1)
                  : cnt_q;
        end
        assign fire[c] = fire_c;
        always_ff @(posedge ClockIn or negedge ResetN) begin
            if (!ResetN) begin
                cfg_q <= {PERIOD_W'(1), 1'b0};
                cnt_q <= '0;
            end else begin
                cfg_q <= cfg_d;
                cnt_q <= cnt_d;
            end
        end
    end

    // The accepted channel is removed before arbitration so the next event can go out on the acceptance edge.
    always_comb begin
        accept = valid_q && EventReady;
        hold = valid_q && !EventReady;
        acc_mask = accept ? NUM_CH'(1) << chan_q : '0;
        arb_pend = pending_q & ~acc_mask;
        ptr_d = accept ? (chan_q == idx_t'(NUM_CH - 1) ? '0 : chan_q + idx_t'(1)) : ptr_q;
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .pending (arb_pend),
        .ptr     (ptr_d),
        .grant   (arb_grant),
        .any     (arb_any)
    );

    // A fresh fire on a still-pending channel folds into the existing flag and flags overrun instead.
    always_comb begin
        pending_d = arb_pend | fire;
        overrun_d = (overrun_q & ~ClearOverrun) | (fire & arb_pend);
        valid_d = hold || arb_any;
        chan_d = hold ? chan_q : arb_grant;
    end

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            presc_q   <= PS_LOAD;
            pending_q <= '0;
            overrun_q <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            chan_q    <= '0;
        end else begin
            presc_q   <= presc_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            chan_q    <= chan_d;
        end
    end

    assign BaseTick = base_tick;
    assign EventValid = valid_q;
    assign EventChannel = chan_q;
    assign Overrun = overrun_q;
endmodule
